// File: rtl/fifo_wr_arb_pkg.sv
// ============================================================================
// fifo_wr_arb_pkg: shared types and helpers for the FIFO write-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fifo_wr_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned IDX_W   = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int unsigned gid_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned m);
        return $clog2(m + 1);
    endfunction

    // Returns {found, index} of the first set bit after ptr, wrapping at n.
    // Iterating downward lets the nearest candidate overwrite farther ones.
    function automatic logic [IDX_W:0] rr_first(input logic [MAX_REQ-1:0] vld,
                                                input logic [IDX_W-1:0]   ptr,
                                                input logic [IDX_W:0]     n);
        logic [IDX_W:0] res;
        logic [IDX_W:0] idx;
        res = '0;
        for (int i = MAX_REQ; i >= 1; i--) begin
            idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (idx >= n) begin
                idx = idx - n;
            end
            if (((IDX_W+1)'(i) <= n) && vld[idx[IDX_W-1:0]]) begin
                res = {1'b1, idx[IDX_W-1:0]};
            end
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ============================================================================
// rr_pick: combinational round-robin selector (first valid after pointer).
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = gid_width(N)
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [IW-1:0] idx_o,
    output logic          found_o
);

    logic [IDX_W:0] pick_res;

    assign pick_res = rr_first(MAX_REQ'(valid_i), IDX_W'(ptr_i), (IDX_W+1)'(N));
    assign idx_o    = IW'(pick_res[IDX_W-1:0]);
    assign found_o  = pick_res[IDX_W];

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// fifo_wr_arbiter: round-robin, burst-atomic sharing of one FIFO write port.
// Optional idle watchdog: FIFO_WR_ARB_TIMEOUT_EN.  Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH_WR  = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                         wr_clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    input  logic [NUM_REQ*WIDTH_WR-1:0]  req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic                         fifo_full_i,
    input  logic                         fifo_almost_full_i,
    output logic                         fifo_wr_en_o,
    output logic [WIDTH_WR-1:0]          fifo_wr_data_o,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id_o,
    output logic                         busy_o
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    ,
    output logic                         err_timeout_o
`endif
);

    localparam int unsigned GID_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = cnt_width(MAX_BURST);
    localparam int unsigned TO_W  = cnt_width(TIMEOUT);

    if ((NUM_REQ < 2) || (NUM_REQ > MAX_REQ)) begin : g_bad_num_req
        $error("fifo_wr_arbiter: NUM_REQ must be 2..16");
    end
    if ((MAX_BURST < 1) || (TIMEOUT < 1)) begin : g_bad_limits
        $error("fifo_wr_arbiter: MAX_BURST and TIMEOUT must be >= 1");
    end

    arb_state_e           state_q;
    logic [GID_W-1:0]     grant_q;
    logic [GID_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     beat_cnt_q;
    logic [CNT_W-1:0]     beat_cnt_d;
    logic                 wr_en_q;
    logic [WIDTH_WR-1:0]  wr_data_q;

    logic [GID_W-1:0]     pick_idx;
    logic                 pick_found;
    logic                 can_write;
    logic                 gnt_valid;
    logic                 gnt_last;
    logic                 xfer;
    logic                 burst_end;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (GID_W)
    ) u_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Registered write output needs one spare entry, hence almost_full gating.
    assign can_write  = !fifo_almost_full_i && !fifo_full_i;
    assign gnt_valid  = req_valid_i[grant_q];
    assign gnt_last   = req_last_i[grant_q];
    assign xfer       = (state_q == BURST) && gnt_valid && can_write;
    assign beat_cnt_d = beat_cnt_q + 1'b1;
    assign burst_end  = gnt_last || (beat_cnt_d == CNT_W'(MAX_BURST));

    always_comb begin
        req_ready_o = '0;
        if ((state_q == BURST) && can_write) begin
            req_ready_o[grant_q] = 1'b1;
        end
    end

`ifdef FIFO_WR_ARB_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt_q;
    logic            err_q;
`endif

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= GID_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            wr_en_q    <= 1'b0;
            wr_data_q  <= '0;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            wr_en_q <= xfer;
            if (xfer) begin
                wr_data_q <= req_data_i[grant_q*WIDTH_WR +: WIDTH_WR];
            end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_found && !fifo_almost_full_i) begin
                        grant_q    <= pick_idx;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                BURST: begin
                    if (xfer) begin
                        beat_cnt_q <= beat_cnt_d;
                        if (burst_end) begin
                            state_q <= IDLE;
                            ptr_q   <= grant_q;
                        end
                    end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
                    if (gnt_valid) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        idle_cnt_q <= '0;
                        err_q      <= 1'b1;
                        state_q    <= IDLE;
                        ptr_q      <= grant_q;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + 1'b1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q == BURST);
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    assign err_timeout_o  = err_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// tb_fifo_wr_arbiter: vector table, directed sequences and random traffic
// checked against a transaction-level arbiter model.  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int MAXB = 4;
    localparam int TO   = 8;

    logic              wr_clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_last;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              fifo_full;
    logic              fifo_almost_full;
    logic              fifo_wr_en;
    logic [W-1:0]      fifo_wr_data;
    logic [1:0]        grant_id;
    logic              busy;
`ifdef FIFO_WR_ARB_TIMEOUT_EN
    logic              err_timeout;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NREQ),
        .WIDTH_WR  (W),
        .MAX_BURST (MAXB),
        .TIMEOUT   (TO)
    ) dut (
        .wr_clk             (wr_clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid),
        .req_last_i         (req_last),
        .req_data_i         (req_data),
        .req_ready_o        (req_ready),
        .fifo_full_i        (fifo_full),
        .fifo_almost_full_i (fifo_almost_full),
        .fifo_wr_en_o       (fifo_wr_en),
        .fifo_wr_data_o     (fifo_wr_data),
        .grant_id_o         (grant_id),
        .busy_o             (busy)
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        ,
        .err_timeout_o      (err_timeout)
`endif
    );

    always #5 wr_clk = ~wr_clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner = -1 when nobody holds the port.
    int         m_owner;
    int         m_beats;
    int         m_last;
    int         m_gid;
    int         m_silent;
    bit         m_wr_en;
    logic [7:0] m_wr_data;
    bit         m_err;
    logic [3:0] m_acc;

    task automatic model_reset();
        m_owner = -1; m_beats = 0; m_last = NREQ - 1; m_gid = 0; m_silent = 0;
        m_wr_en = 0;  m_wr_data = 8'h00; m_err = 0; m_acc = 4'b0000;
    endtask

    task automatic model_next(input logic [3:0] rdy);
        bit nxt_wr = 0;
        bit nxt_err = 0;
        bit found = 0;
        m_acc = 4'b0000;
        if (m_owner < 0) begin
            if (req_valid != 0 && !fifo_almost_full) begin
                for (int off = 1; off <= NREQ; off++) begin
                    int k;
                    k = (m_last + off) % NREQ;
                    if (!found && req_valid[k]) begin
                        found = 1; m_owner = k; m_gid = k; m_beats = 0; m_silent = 0;
                    end
                end
            end
        end else begin
            if (req_valid[m_owner]) m_silent = 0;
            else                    m_silent++;
            if (req_valid[m_owner] && rdy[m_owner]) begin
                m_acc[m_owner] = 1'b1;
                nxt_wr    = 1;
                m_wr_data = req_data[m_owner*W +: W];
                m_beats++;
                if (req_last[m_owner] || m_beats == MAXB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
`ifdef FIFO_WR_ARB_TIMEOUT_EN
            else if (m_silent == TO) begin
                nxt_err = 1;
                m_last  = m_owner;
                m_owner = -1;
            end
`endif
        end
        m_wr_en = nxt_wr;
        m_err   = nxt_err;
    endtask

    // Packet sources and observation queues.
    int left [NREQ];
    int sent [NREQ];
    bit mute [NREQ];
    bit refill;
    int gq[$];
    logic [7:0] wq[$];
    bit prev_busy;
    int n_pulses;

    task automatic clear_drv();
        for (int k = 0; k < NREQ; k++) begin
            left[k] = 0; sent[k] = 0; mute[k] = 0;
        end
        refill = 0;
        fifo_full = 0; fifo_almost_full = 0;
    endtask

    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (refill && left[k] == 0) left[k] = 2;
            req_valid[k] = (left[k] > 0) && !mute[k];
            req_last[k]  = (left[k] == 1);
            req_data[k*W +: W] = {4'(k), 4'(sent[k])};
        end
    endtask

    // Called shortly after a negedge with inputs set; ends at the next negedge.
    task automatic step();
        logic [3:0] rdy;
        #1;
        rdy = (rst_n && m_owner >= 0 && !fifo_almost_full && !fifo_full) ?
              4'(1 << m_owner) : 4'b0000;
        chk("req_ready",  32'(req_ready),  32'(rdy));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr_en));
        if (m_wr_en) chk("fifo_wr_data", 32'(fifo_wr_data), 32'(m_wr_data));
        chk("busy",       32'(busy),       32'(m_owner >= 0));
        chk("grant_id",   32'(grant_id),   32'(m_gid));
`ifdef FIFO_WR_ARB_TIMEOUT_EN
        chk("err_timeout", 32'(err_timeout), 32'(m_err));
        if (err_timeout) n_pulses++;
`endif
        if (fifo_wr_en) wq.push_back(fifo_wr_data);
        if (busy && !prev_busy) gq.push_back(int'(grant_id));
        prev_busy = busy;
        if (rst_n) model_next(rdy);
        for (int k = 0; k < NREQ; k++) begin
            if (m_acc[k]) begin left[k]--; sent[k]++; end
        end
        @(posedge wr_clk);
        @(negedge wr_clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_busy",  32'(busy),       32'd0);
        step();
        rst_n = 1'b1;
        gq.delete(); wq.delete(); prev_busy = 0;
    endtask

    task automatic run_until_grants(input int n, input int budget);
        int b = budget;
        while (gq.size() < n && b > 0) begin drive(); step(); b--; end
        chk("grant_budget", 32'(gq.size()), 32'(n));
    endtask

    task automatic run_until_sent(input int k, input int n, input int budget);
        int b = budget;
        while (sent[k] < n && b > 0) begin drive(); step(); b--; end
        chk("sent_budget", 32'(sent[k]), 32'(n));
    endtask

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] d0;
        logic       afull;
        logic [3:0] e_ready;
        logic       e_wr_en;
        logic [7:0] e_data;
        logic       e_busy;
        logic [1:0] e_gid;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'b0001, 4'b0000, 8'hA1, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};
        tbl[1] = '{4'b0001, 4'b0000, 8'hA1, 1'b0, 4'b0001, 1'b0, 8'h00, 1'b1, 2'd0};
        tbl[2] = '{4'b0001, 4'b0000, 8'hA2, 1'b0, 4'b0001, 1'b1, 8'hA1, 1'b1, 2'd0};
        tbl[3] = '{4'b0001, 4'b0001, 8'hA3, 1'b0, 4'b0001, 1'b1, 8'hA2, 1'b1, 2'd0};
        tbl[4] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b1, 8'hA3, 1'b0, 2'd0};
        tbl[5] = '{4'b0000, 4'b0000, 8'h00, 1'b0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0};

        clear_drv();
        req_valid = '0; req_last = '0; req_data = '0;
        prev_busy = 0; n_pulses = 0;
        rst_n = 1'b0;
        @(negedge wr_clk);
        do_reset();

        // Single requester, three beats.
        for (int i = 0; i < 6; i++) begin
            req_valid = tbl[i].valid;
            req_last  = tbl[i].last;
            req_data  = {24'h0, tbl[i].d0};
            fifo_almost_full = tbl[i].afull;
            #1;
            chk("tbl_ready", 32'(req_ready),  32'(tbl[i].e_ready));
            chk("tbl_wr_en", 32'(fifo_wr_en), 32'(tbl[i].e_wr_en));
            if (tbl[i].e_wr_en) chk("tbl_data", 32'(fifo_wr_data), 32'(tbl[i].e_data));
            chk("tbl_busy",  32'(busy),       32'(tbl[i].e_busy));
            chk("tbl_gid",   32'(grant_id),   32'(tbl[i].e_gid));
            step();
        end

        // Round robin with 2-beat packets from everyone.
        clear_drv(); drive(); do_reset();
        refill = 1;
        run_until_grants(5, 60);
        for (int i = 0; i < 5 && i < gq.size(); i++)
            chk("rr_order", 32'(gq[i]), 32'(i % NREQ));
        chk("rr_writes", 32'(wq.size() >= 8), 32'd1);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            chk("rr_data", 32'(wq[i]), 32'({4'(i / 2), 4'(i % 2)}));

        // Burst cap: req1 streams without last, req2 waits.
        clear_drv(); drive(); do_reset();
        left[1] = 10; left[2] = 2;
        run_until_grants(3, 40);
        for (int i = 0; i < 3 && i < gq.size(); i++)
            chk("cap_order", 32'(gq[i]), 32'((i == 1) ? 2 : 1));
        for (int i = 0; i < 6 && i < wq.size(); i++)
            chk("cap_data", 32'(wq[i]), 32'((i < 4) ? (8'h10 + i) : (8'h20 + i - 4)));

        // Backpressure after the second beat.
        begin
            int w0;
            clear_drv(); drive(); do_reset();
            left[0] = 4;
            run_until_sent(0, 2, 10);
            w0 = wq.size();
            fifo_almost_full = 1;
            drive(); step(); drive(); step();
            fifo_full = 1;
            drive(); step(); drive(); step();
            fifo_full = 0;
            drive(); step();
            chk("bp_window_writes", 32'(wq.size() - w0), 32'd1);
            fifo_almost_full = 0;
            run_until_sent(0, 4, 10);
            drive(); step(); drive(); step();
            chk("bp_count", 32'(wq.size()), 32'd4);
            for (int i = 0; i < 4 && i < wq.size(); i++)
                chk("bp_data", 32'(wq[i]), 32'(i));
        end

        // Mid-burst stall, then reset while the burst is open.
        clear_drv(); drive(); do_reset();
        left[0] = 6; left[3] = 2;
        run_until_sent(0, 2, 10);
        mute[0] = 1;
        repeat (5) begin drive(); step(); end
        chk("stall_grants", 32'(gq.size()), 32'd1);
        chk("stall_req3",   32'(sent[3]),   32'd0);
        mute[0] = 0;
        drive(); step();
        chk("stall_busy", 32'(busy), 32'd1);
        drive(); do_reset();
        run_until_grants(1, 10);
        if (gq.size() > 0) chk("post_reset_grant", 32'(gq[0]), 32'd0);

`ifdef FIFO_WR_ARB_TIMEOUT_EN
        // Silent granted requester is dropped after TO idle cycles.
        clear_drv(); drive(); do_reset();
        n_pulses = 0;
        left[2] = 6; left[3] = 2;
        run_until_sent(2, 1, 10);
        mute[2] = 1;
        run_until_grants(2, 20);
        chk("to_pulses", 32'(n_pulses), 32'd1);
        if (gq.size() > 1) chk("to_next_grant", 32'(gq[1]), 32'd3);
`endif

        // Random traffic against the model.
        clear_drv(); drive(); do_reset();
        for (int c = 0; c < 600; c++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom);
            req_data  = $urandom;
            fifo_almost_full = ($urandom_range(0, 6) == 0);
            fifo_full        = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0) do_reset();
            else                            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
